// File: rtl/major_state_timing_gen.sv
// Central timing and major-state sequencer for the PDP-8/I model.
// Produces one-hot time states/pulses, holds RUN, and steps F/D/E/B.
//
// state | meaning
// F     | Fetch: read instruction, decide defer/execute
// D     | Defer: indirect address fetch
// E     | Execute: operand cycle of memory-reference instruction
// B     | Break: data-break cycle granted to an I/O device
module major_state_timing_gen #(
    parameter int TS_CYCLES = 4,
    parameter int TP_WIDTH  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_cont,
    input  logic       key_stop,
    input  logic       sw_sing_step,
    input  logic       sw_sing_inst,
    input  logic       halt_req,
    input  logic       next_defer,
    input  logic       next_execute,
    input  logic       brk_rq,
    output logic       run,
    output logic [3:0] ts,
    output logic [3:0] tp,
    output logic [3:0] state,
    output logic       mem_start,
    output logic       cycle_done
);

    localparam int CW = $clog2(TS_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TS_CYCLES - 1);
    localparam logic [CW-1:0] TP_FIRST = CW'(TS_CYCLES - TP_WIDTH);

    typedef enum logic [3:0] {
        ST_F = 4'b0001,
        ST_D = 4'b0010,
        ST_E = 4'b0100,
        ST_B = 4'b1000
    } major_t;

    major_t          state_q, state_d, major_nxt;
    logic            run_q, run_d;
    logic [3:0]      ts_q, ts_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            stop_q, stop_d;
    logic            start_prev, cont_prev, stop_prev;
    logic            start_edge, cont_edge, stop_edge;
    logic            halt_stop;
    logic            stop_now;

    assign start_edge = key_start & ~start_prev;
    assign cont_edge  = key_cont  & ~cont_prev;
    assign stop_edge  = key_stop  & ~stop_prev;
    // A stop request seen in the boundary clock itself still counts here.
    assign halt_stop  = run_q & (stop_edge | halt_req);

    // Major state that follows the current cycle, including break override.
    always_comb begin
        major_nxt = ST_F;
        case (state_q)
            ST_F: begin
                if (next_defer)        major_nxt = ST_D;
                else if (next_execute) major_nxt = ST_E;
                else                   major_nxt = ST_F;
            end
            ST_D:    major_nxt = next_execute ? ST_E : ST_F;
            default: major_nxt = ST_F;
        endcase
        if (major_nxt == ST_F && brk_rq) major_nxt = ST_B;
    end

    assign stop_now = stop_q | halt_stop | sw_sing_step
                    | (sw_sing_inst && major_nxt == ST_F);

    // Run control, time-state sequencing and stop latch next-state logic.
    always_comb begin
        run_d   = run_q;
        ts_d    = ts_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        stop_d  = stop_q;
        if (!run_q) begin
            // A STOP edge coinciding with START/CONT suppresses the start.
            if (!stop_edge && (start_edge || cont_edge)) begin
                run_d  = 1'b1;
                stop_d = 1'b0;
                if (start_edge) state_d = ST_F;
            end
        end else begin
            if (halt_stop) stop_d = 1'b1;
            if (ts_q == 4'b0000) begin
                ts_d  = 4'b0001;
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (ts_q[3]) begin
                    state_d = major_nxt;
                    if (stop_now) begin
                        run_d = 1'b0;
                        ts_d  = 4'b0000;
                    end else begin
                        ts_d  = 4'b0001;
                    end
                end else begin
                    ts_d = {ts_q[2:0], 1'b0};
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers; key history tracks the keys during reset so held keys do not act.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q      <= 1'b0;
            ts_q       <= 4'b0000;
            cnt_q      <= '0;
            state_q    <= ST_F;
            stop_q     <= 1'b0;
            start_prev <= key_start;
            cont_prev  <= key_cont;
            stop_prev  <= key_stop;
        end else begin
            run_q      <= run_d;
            ts_q       <= ts_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            stop_q     <= stop_d;
            start_prev <= key_start;
            cont_prev  <= key_cont;
            stop_prev  <= key_stop;
        end
    end

    assign run        = run_q;
    assign ts         = ts_q;
    assign state      = state_q;
    assign tp         = ts_q & {4{cnt_q >= TP_FIRST}};
    assign mem_start  = ts_q[0] & (cnt_q == '0);
    assign cycle_done = ts_q[3] & (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_major_state_timing_gen.sv
// Directed bench for the major-state timing generator (TS_CYCLES=4, TP_WIDTH=1).
module tb_major_state_timing_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_start = 1'b0, key_cont = 1'b0, key_stop = 1'b0;
    logic       sw_sing_step = 1'b0, sw_sing_inst = 1'b0, halt_req = 1'b0;
    logic       next_defer = 1'b0, next_execute = 1'b0, brk_rq = 1'b0;
    logic       run, mem_start, cycle_done;
    logic [3:0] ts, tp, state;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] F = 4'b0001, D = 4'b0010, E = 4'b0100, B = 4'b1000;

    major_state_timing_gen #(.TS_CYCLES(4), .TP_WIDTH(1)) dut (
        .clk(clk), .rst(rst),
        .key_start(key_start), .key_cont(key_cont), .key_stop(key_stop),
        .sw_sing_step(sw_sing_step), .sw_sing_inst(sw_sing_inst),
        .halt_req(halt_req), .next_defer(next_defer),
        .next_execute(next_execute), .brk_rq(brk_rq),
        .run(run), .ts(ts), .tp(tp), .state(state),
        .mem_start(mem_start), .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until cycle_done is seen; n is the number of clocks taken.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cycle_done && n < 64);
        if (!cycle_done) check("cycle_done_timeout", cycle_done, 1);
    endtask

    task automatic press_start();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
    endtask

    task automatic press_cont();
        key_cont = 1'b1;
        tick();
        key_cont = 1'b0;
    endtask

    int n;
    int done_cnt;

    initial begin
        // Reset state
        ticks(3);
        rst = 1'b0;
        tick();
        check("rst_run", run, 0);
        check("rst_ts", ts, 0);
        check("rst_tp", tp, 0);
        check("rst_state", state, F);
        check("rst_mem_start", mem_start, 0);
        check("rst_cycle_done", cycle_done, 0);

        // 1: plain Fetch cycle timing
        press_start();
        check("t1_run_clk0", run, 1);
        check("t1_ts_clk0", ts, 0);
        tick();
        check("t1_mem_start_clk1", mem_start, 1);
        check("t1_ts_clk1", ts, 4'b0001);
        check("t1_tp_clk1", tp, 0);
        ticks(3);
        check("t1_tp_clk4", tp, 4'b0001);
        check("t1_ts_clk4", ts, 4'b0001);
        ticks(12);
        check("t1_tp_clk16", tp, 4'b1000);
        check("t1_done_clk16", cycle_done, 1);
        tick();
        check("t1_mem_start_clk17", mem_start, 1);
        check("t1_state_clk17", state, F);
        check("t1_run_clk17", run, 1);

        // 2: F -> D -> E -> F, sing inst stops after E
        next_defer = 1'b1;
        wait_done(n);
        check("t1_period", n, 15);
        tick();
        check("t2_state_d", state, D);
        check("t2_mem_start_d", mem_start, 1);
        next_defer = 1'b0;
        next_execute = 1'b1;
        wait_done(n);
        tick();
        check("t2_state_e", state, E);
        next_execute = 1'b0;
        sw_sing_inst = 1'b1;
        wait_done(n);
        tick();
        check("t2_inst_run", run, 0);
        check("t2_inst_state", state, F);
        check("t2_inst_ts", ts, 0);
        sw_sing_inst = 1'b0;

        // 3: sing step, then CONT resumes in stored state
        next_defer = 1'b1;
        sw_sing_step = 1'b1;
        press_start();
        wait_done(n);
        tick();
        check("t3_step_run", run, 0);
        check("t3_step_state", state, D);
        check("t3_step_ts", ts, 0);
        next_defer = 1'b0;
        next_execute = 1'b1;
        press_cont();
        check("t3_cont_run", run, 1);
        check("t3_cont_state", state, D);
        wait_done(n);
        tick();
        check("t3_step2_run", run, 0);
        check("t3_step2_state", state, E);
        sw_sing_step = 1'b0;
        next_execute = 1'b0;

        // 4: data break B,B,F then break ignored when next is D
        press_cont();
        brk_rq = 1'b1;
        wait_done(n);
        tick();
        check("t4_brk1", state, B);
        wait_done(n);
        tick();
        check("t4_brk2", state, B);
        brk_rq = 1'b0;
        wait_done(n);
        tick();
        check("t4_brk_end", state, F);
        next_defer = 1'b1;
        brk_rq = 1'b1;
        wait_done(n);
        tick();
        check("t4_defer_wins", state, D);
        check("t4_run", run, 1);
        brk_rq = 1'b0;
        next_defer = 1'b0;

        // 5: STOP at clk 5 completes the cycle
        ticks(4);
        key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
        check("t5_run_after_stop", run, 1);
        wait_done(n);
        check("t5_remaining", n, 10);
        check("t5_ts_last", ts, 4'b1000);
        tick();
        check("t5_run_off", run, 0);
        check("t5_ts_off", ts, 0);
        check("t5_state", state, F);
        key_start = 1'b1;
        key_stop = 1'b1;
        tick();
        key_start = 1'b0;
        key_stop = 1'b0;
        tick();
        check("t5_start_stop_run", run, 0);
        check("t5_start_stop_ts", ts, 0);

        // STOP edge and halt_req in the boundary clock itself
        press_start();
        wait_done(n);
        key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
        check("t5_stop_boundary", run, 0);
        press_start();
        wait_done(n);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("t5_halt_boundary", run, 0);

        // 6: reset mid-cycle
        next_defer = 1'b1;
        press_start();
        wait_done(n);
        tick();
        next_defer = 1'b0;
        check("t6_state_d", state, D);
        ticks(8);
        rst = 1'b1;
        tick();
        check("t6_rst_run", run, 0);
        check("t6_rst_ts", ts, 0);
        check("t6_rst_tp", tp, 0);
        check("t6_rst_state", state, F);
        done_cnt = int'(cycle_done);
        key_start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            done_cnt += int'(cycle_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            done_cnt += int'(cycle_done);
        end
        check("t6_no_cycle_done", done_cnt, 0);
        check("t6_held_key_ignored", run, 0);
        key_start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
